// File: rtl/fetch_unit_pkg.sv
// core_general: parameters shared by the RockWave core blocks.
//   XLEN         - data / PC width
//   AWIDTH       - instruction ROM word-address width
//   ROM_DEPTH    - number of ROM words
//   RESET_VECTOR - PC value after reset
//   PC_STEP      - sequential PC increment (one 32-bit instruction)
package core_general;
   localparam int          XLEN         = 32;
   localparam int          AWIDTH       = 12;
   localparam int          ROM_DEPTH    = 1 << AWIDTH;
   localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-ROM bus between the fetch logic and the ROM.
//   inst_addr - ROM word address (driven by fetch)
//   inst_data - ROM read data, one cycle after the address (driven by ROM)
// There is no handshake: the ROM always answers one cycle after the
// address is presented.
interface fetch_unit_if;
   logic [core_general::AWIDTH-1:0] inst_addr;
   logic [core_general::XLEN-1:0]   inst_data;

   modport master (output inst_addr, input  inst_data);
   modport slave  (input  inst_addr, output inst_data);
endinterface

// File: rtl/fetch_unit_rom.sv
// rom: 4096 x 32 synchronous instruction ROM.
//   clk   - clock
//   rst_n - asynchronous reset, active high (clears the output register)
//   addr  - word address
//   qout  - registered read data, mem[addr] one cycle after addr
// The array has no write port; its contents are placed by the simulation
// environment before the first clock.
module rom
   import core_general::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] addr,
   output logic [XLEN-1:0]   qout
);

   logic [XLEN-1:0] mem [0:ROM_DEPTH-1];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         qout <= '0;
      end else begin
         qout <= mem[addr];
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage (PC register, +4 adder, jump mux,
// instruction hold register).
//   clk, rst_n       - clock; asynchronous reset, active high
//   phase_fetch      - one-hot phase strobe, fetch cycle
//   phase_writeback  - one-hot phase strobe, writeback cycle (PC update)
//   jump_state_wf    - load regdata_for_pc instead of pc+4 at writeback
//   regdata_for_pc   - jump target
//   rom_bus          - ROM address out / read data in
//   curr_pc_fd       - PC of the instruction in flight
//   next_pc_fd       - curr_pc_fd + 4
//   inst             - fetched instruction
//   stall_fetch      - stall request, reserved for wait-state memories
module fetch_unit
   import core_general::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            phase_fetch,
   input  logic            phase_writeback,
   input  logic            jump_state_wf,
   input  logic [XLEN-1:0] regdata_for_pc,
   fetch_unit_if.master    rom_bus,
   output logic [XLEN-1:0] curr_pc_fd,
   output logic [XLEN-1:0] next_pc_fd,
   output logic [XLEN-1:0] inst,
   output logic            stall_fetch
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inst_q;
   logic            r_decode;   // phase_fetch delayed one cycle
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_pc_next;

   assign w_pc_plus4 = r_pc + PC_STEP;   // wraps mod 2^32
   // Jump targets are stored as-is, low bits included.
   assign w_pc_next  = jump_state_wf ? regdata_for_pc : w_pc_plus4;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_pc     <= RESET_VECTOR;
         r_decode <= 1'b0;
         r_inst_q <= '0;
      end else begin
         r_decode <= phase_fetch;
         // Capture ROM data at the edge ending decode; it then stays
         // valid after the ROM output moves on.
         if (r_decode) begin
            r_inst_q <= rom_bus.inst_data;
         end
         if (phase_writeback) begin
            r_pc <= w_pc_next;
         end
      end
   end

   // Word address ignores pc[1:0] and everything above the ROM size,
   // so the ROM aliases every 16 KiB.
   assign rom_bus.inst_addr = r_pc[AWIDTH+1:2];

   assign curr_pc_fd  = r_pc;
   assign next_pc_fd  = w_pc_plus4;
   assign inst        = r_decode ? rom_bus.inst_data : r_inst_q;
   assign stall_fetch = 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import core_general::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;                 // active high: 1 holds reset
  always #5 clk = ~clk;

  logic            phase_fetch = 1'b0;
  logic            phase_writeback = 1'b0;
  logic            jump_state_wf = 1'b0;
  logic [XLEN-1:0] regdata_for_pc = '0;
  logic [XLEN-1:0] curr_pc_fd, next_pc_fd, inst;
  logic            stall_fetch;

  fetch_unit_if rom_bus ();

  fetch_unit u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .phase_fetch     (phase_fetch),
    .phase_writeback (phase_writeback),
    .jump_state_wf   (jump_state_wf),
    .regdata_for_pc  (regdata_for_pc),
    .rom_bus         (rom_bus.master),
    .curr_pc_fd      (curr_pc_fd),
    .next_pc_fd      (next_pc_fd),
    .inst            (inst),
    .stall_fetch     (stall_fetch)
  );

  rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (rom_bus.inst_addr),
    .qout  (rom_bus.inst_data)
  );

  // ---------------- model / scoreboard ----------------
  logic [XLEN-1:0] mem_model [0:ROM_DEPTH-1];
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] exp_q[$];          // expected PC per fetched instruction
  logic [XLEN-1:0] exp_inst_q[$];     // expected instruction word
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the active edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch cycle, then check the decode cycle against the scoreboard.
  task automatic fetch_and_decode(input string tag);
    logic [XLEN-1:0] e_pc, e_inst, a_pc;
    exp_q.push_back(m_pc);
    a_pc = m_pc;
    exp_inst_q.push_back(mem_model[a_pc[13:2]]);
    phase_fetch = 1'b1;
    cycle();
    phase_fetch = 1'b0;
    e_pc = exp_q.pop_front();
    e_inst = exp_inst_q.pop_front();
    check({tag, ".curr_pc"}, curr_pc_fd, e_pc);
    check({tag, ".next_pc"}, next_pc_fd, e_pc + 32'd4);
    check({tag, ".inst_addr"}, {20'd0, rom_bus.inst_addr}, {20'd0, e_pc[13:2]});
    check({tag, ".inst"}, inst, e_inst);
    check({tag, ".inst_data"}, rom_bus.inst_data, e_inst);
    check({tag, ".stall"}, {31'd0, stall_fetch}, 32'd0);
    // execute: instruction held, PC unchanged
    cycle();
    check({tag, ".hold_inst"}, inst, e_inst);
    check({tag, ".hold_pc"}, curr_pc_fd, e_pc);
  endtask

  // memory + writeback; jump request is presented from memory onward.
  task automatic finish_instr(input string tag, input logic jmp, input logic [XLEN-1:0] tgt);
    logic [XLEN-1:0] held;
    held = m_pc;
    cycle();                          // now in memory
    jump_state_wf = jmp;
    regdata_for_pc = tgt;
    cycle();                          // now in writeback
    check({tag, ".wb_pc_stable"}, curr_pc_fd, held);
    phase_writeback = 1'b1;
    cycle();                          // next instruction's fetch slot
    phase_writeback = 1'b0;
    jump_state_wf = 1'b0;
    regdata_for_pc = $urandom;
    m_pc = jmp ? tgt : m_pc + 32'd4;
    check({tag, ".pc_after_wb"}, curr_pc_fd, m_pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tmp;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      tmp = $urandom;
      tmp[19] = 1'b1;                 // keeps every word non-zero
      mem_model[i] = {tmp[19:0], i[11:0]};
      u_rom.mem[i] = mem_model[i];
    end
    m_pc = RESET_VECTOR;

    // reset held for 2 cycles
    cycle();
    check("rst.curr_pc", curr_pc_fd, 32'h8000_0000);
    check("rst.next_pc", next_pc_fd, 32'h8000_0004);
    check("rst.inst_addr", {20'd0, rom_bus.inst_addr}, 32'd0);
    check("rst.inst", inst, 32'd0);
    check("rst.stall", {31'd0, stall_fetch}, 32'd0);
    cycle();
    rst_n = 1'b0;

    fetch_and_decode("seq0");
    finish_instr("seq0", 1'b0, 32'h0);
    fetch_and_decode("seq1");
    finish_instr("seq1", 1'b0, 32'h0);
    fetch_and_decode("pre_jump");
    finish_instr("pre_jump", 1'b1, 32'h8000_0100);
    fetch_and_decode("jump_0100");
    check("jump_0100.addr_const", {20'd0, rom_bus.inst_addr}, 32'h040);
    finish_instr("jump_0100", 1'b0, 32'h0);
    fetch_and_decode("after_0104");
    check("after_0104.addr_const", {20'd0, rom_bus.inst_addr}, 32'h041);
    finish_instr("after_0104", 1'b0, 32'h0);
    fetch_and_decode("after_0108");
    check("after_0108.addr_const", {20'd0, rom_bus.inst_addr}, 32'h042);
    finish_instr("after_0108", 1'b1, 32'hFFFF_FFFC);

    // wrap at the top of the address space
    fetch_and_decode("wrap");
    check("wrap.addr_const", {20'd0, rom_bus.inst_addr}, 32'hFFF);
    check("wrap.next_const", next_pc_fd, 32'h0000_0000);
    finish_instr("wrap", 1'b0, 32'h0);
    check("wrap.pc_zero", curr_pc_fd, 32'h0000_0000);
    fetch_and_decode("zero");

    // unaligned target stored unmodified; pc[1:0] ignored for address
    finish_instr("zero", 1'b1, 32'h8000_0013);
    fetch_and_decode("unaligned");
    check("unaligned.addr_const", {20'd0, rom_bus.inst_addr}, 32'h004);
    finish_instr("unaligned", 1'b0, 32'h0);
    fetch_and_decode("unaligned_step");

    // random jumps, including aliased high addresses
    for (int k = 0; k < 4; k++) begin
      finish_instr("rand", 1'b1, $urandom);
      fetch_and_decode("rand");
    end

    // reset asserted during execute: takes effect without a clock edge
    finish_instr("pre_rst", 1'b0, 32'h0);
    phase_fetch = 1'b1;
    cycle();
    phase_fetch = 1'b0;
    cycle();                          // execute
    rst_n = 1'b1;
    #1;
    check("midrst.curr_pc", curr_pc_fd, 32'h8000_0000);
    check("midrst.inst", inst, 32'd0);
    check("midrst.stall", {31'd0, stall_fetch}, 32'd0);
    cycle();
    rst_n = 1'b0;
    m_pc = RESET_VECTOR;
    fetch_and_decode("post_rst");
    finish_instr("post_rst", 1'b0, 32'h0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
